// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver, 8N1 by default.
// Define UART_RX_PARITY_EN to receive 8E1 frames; parity_err is then live,
// otherwise it is tied low and the PARITY state is not built.
// Each received byte appears on rx_data with a one-cycle rx_valid strobe.
// Malformed frames are dropped and flagged. There is no backpressure.
module uart_rx_core #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int CLKS_PER_TICK = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLKS_PER_TICK - 1);
    localparam logic [TW-1:0] TCNT_MAX  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TCNT_MID  = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BRK    = 3'd5
    } state_t;

    state_t          state, state_n;
    logic            rxd_p0, rxs;
    logic [PW-1:0]   presc;
    logic [TW-1:0]   tcnt;
    logic            tick, mid_smp;
    logic            clr_cnt, idx_clr, shift_en, stop_smp;
    logic [7:0]      shreg;
    logic [2:0]      idx;
    logic            vld_p0, ferr_p0;
`ifdef UART_RX_PARITY_EN
    logic            par_chk, par_bad, perr_p0;
`endif

    assign tick    = (presc == PRESC_MAX);
    assign mid_smp = tick && (tcnt == TCNT_MID);

    // Two-flop synchronizer. Both flops reset high so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rxd_p0 <= 1'b1;
            rxs    <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxs    <= rxd_p0;
        end
    end

    // Prescaler and oversample tick counter. Both restart on entry to START so that mid-bit phase follows the start edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            presc <= '0;
            tcnt  <= '0;
        end else if (clr_cnt) begin
            presc <= '0;
            tcnt  <= '0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                tcnt <= (tcnt == TCNT_MAX) ? '0 : tcnt + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and sampling controls. Every sample is taken at the same mid-bit tick phase.
    always_comb begin
        state_n  = state;
        clr_cnt  = 1'b0;
        idx_clr  = 1'b0;
        shift_en = 1'b0;
        stop_smp = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_chk  = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!rxs) begin
                    state_n = S_START;
                    clr_cnt = 1'b1;
                end
            end
            S_START: begin
                if (mid_smp) begin
                    if (rxs) begin
                        state_n = S_IDLE;
                    end else begin
                        state_n = S_DATA;
                        idx_clr = 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (mid_smp) begin
                    shift_en = 1'b1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid_smp) begin
                    par_chk = 1'b1;
                    state_n = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid_smp) begin
                    stop_smp = 1'b1;
                    state_n  = rxs ? S_IDLE : S_BRK;
                end
            end
            S_BRK: begin
                if (rxs) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Deserializer and status pipeline. The stop-bit verdict is registered once more so the strobes land one edge after the sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shreg      <= '0;
            idx        <= '0;
            vld_p0     <= 1'b0;
            ferr_p0    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad    <= 1'b0;
            perr_p0    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            if (idx_clr) begin
                idx <= '0;
            end else if (shift_en) begin
                shreg <= {rxs, shreg[7:1]};
                idx   <= idx + 3'd1;
            end
`ifdef UART_RX_PARITY_EN
            if (par_chk) begin
                par_bad <= rxs ^ (^shreg);
            end
            vld_p0     <= stop_smp & rxs & ~par_bad;
            perr_p0    <= stop_smp & rxs & par_bad;
            parity_err <= perr_p0;
`else
            vld_p0     <= stop_smp & rxs;
`endif
            ferr_p0   <= stop_smp & ~rxs;
            rx_valid  <= vld_p0;
            frame_err <= ferr_p0;
            if (vld_p0) begin
                rx_data <= shreg;
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: self-checking bench for uart_rx_core at 16 clocks per bit.
// It uses a vector table, hand sequences for the corner cases, and random frames
// checked against a frame-level model. It follows UART_RX_PARITY_EN like the DUT.
module tb_uart_rx_core;

    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam int STOPK = 10;
`else
    localparam int STOPK = 9;
`endif
    // Edge of the status strobe relative to T0: the stop-bit sample edge plus one.
    localparam int EVT_LAT = 2 + STOPK * BIT_CLKS + BIT_CLKS / 2 + 1;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int par_flip_n = 0;

    typedef struct {
        int         kind;   // 0 valid, 1 frame error, 2 parity error
        logic [7:0] data;
        int         cyc;
    } ev_t;
    ev_t evq[$];

    typedef struct {
        logic [7:0] d;
        logic       stopb;
        int         hold;
        int         kind;
        logic [7:0] exp_rx;
    } vec_t;
    vec_t vt[6];

    uart_rx_core #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (100_000),
        .OVERSAMPLE(16)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every strobe, sampled on the falling edge.
    always @(negedge clk) begin
        ev_t e;
        e.data = rx_data;
        e.cyc  = cyc;
        if (rx_valid)   begin e.kind = 0; evq.push_back(e); end
        if (frame_err)  begin e.kind = 1; evq.push_back(e); end
        if (parity_err) begin e.kind = 2; evq.push_back(e); end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rxd = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stopb, input int hold, output int t0);
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ (par_flip_n != 0));
`endif
        drive_bit(stopb);
        if (!stopb) idle(hold);
        rxd = 1'b1;
    endtask

    task automatic expect_one(input string nm, input int t0, input int kind, input logic [7:0] data);
        chk({nm, "_count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            chk({nm, "_kind"}, evq[0].kind, kind);
            chk({nm, "_data"}, int'(evq[0].data), int'(data));
            chk({nm, "_lat"}, evq[0].cyc - t0, EVT_LAT);
        end
        evq.delete();
    endtask

    initial begin
        int         t0;
        int         tb2b[3];
        logic [7:0] b2b[3];
        logic [7:0] exp_rx;
        logic [7:0] ab;
        logic [7:0] d;
        logic       stopb;
        int         kind;
        int         gap;

        vt[0] = '{8'hA5, 1'b1, 0,  0, 8'hA5};
        vt[1] = '{8'h00, 1'b1, 0,  0, 8'h00};
        vt[2] = '{8'h55, 1'b0, 40, 1, 8'h00};
        vt[3] = '{8'h7E, 1'b1, 0,  0, 8'h7E};
        vt[4] = '{8'hC3, 1'b0, 10, 1, 8'h7E};
        vt[5] = '{8'h81, 1'b1, 0,  0, 8'h81};

        rxd   = 1'b1;
        n_rst = 1'b0;
        idle(3);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_frame_err", int'(frame_err), 0);
        chk("rst_parity_err", int'(parity_err), 0);
        n_rst = 1'b1;
        idle(5);
        evq.delete();

        // Vector table: single frames, good and framing-error.
        for (int i = 0; i < 6; i++) begin
            send_frame(vt[i].d, vt[i].stopb, vt[i].hold, t0);
            idle(20);
            expect_one($sformatf("vec%0d", i), t0, vt[i].kind, vt[i].exp_rx);
            chk($sformatf("vec%0d_rx_data", i), int'(rx_data), int'(vt[i].exp_rx));
        end

        // Back-to-back frames with a single stop bit.
        b2b[0] = 8'h01; b2b[1] = 8'h80; b2b[2] = 8'hFF;
        for (int j = 0; j < 3; j++) send_frame(b2b[j], 1'b1, 0, tb2b[j]);
        idle(20);
        chk("b2b_count", evq.size(), 3);
        for (int j = 0; j < 3 && j < evq.size(); j++) begin
            chk($sformatf("b2b%0d_kind", j), evq[j].kind, 0);
            chk($sformatf("b2b%0d_data", j), int'(evq[j].data), int'(b2b[j]));
            chk($sformatf("b2b%0d_lat", j), evq[j].cyc - tb2b[j], EVT_LAT);
        end
        evq.delete();

        // Short low glitch: no strobe, then a clean frame.
        rxd = 1'b0;
        idle(5);
        rxd = 1'b1;
        idle(40);
        chk("glitch_count", evq.size(), 0);
        send_frame(8'h3C, 1'b1, 0, t0);
        idle(10);
        expect_one("after_glitch", t0, 0, 8'h3C);

        // Stop bit low, line held low: one frame_err, no retrigger while low.
        send_frame(8'h55, 1'b0, 40, t0);
        idle(20);
        expect_one("break", t0, 1, 8'h3C);
        chk("break_rx_data", int'(rx_data), 8'h3C);

        // Asynchronous reset during data bit 4.
        ab = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(ab[i]);
        rxd = ab[4];
        idle(6);
        n_rst = 1'b0;
        #1;
        chk("midrst_rx_data", int'(rx_data), 0);
        chk("midrst_rx_valid", int'(rx_valid), 0);
        idle(3);
        rxd   = 1'b1;
        n_rst = 1'b1;
        idle(30);
        chk("midrst_count", evq.size(), 0);
        send_frame(8'hC3, 1'b1, 0, t0);
        idle(10);
        expect_one("after_rst", t0, 0, 8'hC3);
        exp_rx = 8'hC3;

`ifdef UART_RX_PARITY_EN
        // Parity: correct bit, then inverted bit.
        par_flip_n = 0;
        send_frame(8'h07, 1'b1, 0, t0);
        idle(10);
        expect_one("par_ok", t0, 0, 8'h07);
        par_flip_n = 1;
        send_frame(8'h07, 1'b1, 0, t0);
        idle(10);
        expect_one("par_bad", t0, 2, 8'h07);
        par_flip_n = 0;
        exp_rx = 8'h07;
`endif

        // Random frames against the frame-level model.
        for (int n = 0; n < 24; n++) begin
            d     = 8'($urandom);
            stopb = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
            par_flip_n = ($urandom_range(0, 3) == 0) ? 1 : 0;
`endif
            if (!stopb)               kind = 1;
            else if (par_flip_n != 0) kind = 2;
            else begin
                kind   = 0;
                exp_rx = d;
            end
            send_frame(d, stopb, $urandom_range(0, 30), t0);
            gap = stopb ? $urandom_range(0, 12) : $urandom_range(4, 12);
            idle(gap);
            expect_one($sformatf("rnd%0d", n), t0, kind, exp_rx);
        end
        par_flip_n = 0;
        idle(5);
        chk("final_rx_data", int'(rx_data), int'(exp_rx));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
